uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
- UART receiver plus command filter that sits directly upstream of the servo PWM driver.
- Deserialises 8N1 bytes from the host serial line and validates them against the servo command set (ASCII '1'..'4' = 8'd49..8'd52).
- Drives the driver's 8-bit command input with a level-held register that changes only when a valid command is accepted.
- Also reports per-frame status pulses for debug LEDs / counters.

Parameters:
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range 8..65535.
- CMD_MIN, 8'd49, lowest accepted command byte.
- CMD_MAX, 8'd52, highest accepted command byte.
- RESET_CMD, 8'd49, value of cmd_out after reset (servo home position).
- FILTER_EN, 1, 1 = accept only CMD_MIN..CMD_MAX; 0 = accept every well-framed byte.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  asynchronous serial input, idle high.
- cmd_out  out  8  held command byte to the PWM driver's da_in.
- rx_done  out  1  one-cycle pulse: byte accepted, cmd_out updated.
- cmd_reject  out  1  one-cycle pulse: well-framed byte outside the command range (FILTER_EN=1 only).
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- One clock domain; reset is asynchronous and active-low, on clk and rst_n.
- Reset values: cmd_out=RESET_CMD; rx_done=0; cmd_reject=0; frame_err=0; busy=0. Synchroniser flops reset to 1; FSM resets to IDLE; counters and shift register reset to 0.
- rx passes through a 2-flop synchroniser, then a third flop (rx_d) for edge detection.
- Start detect = synchronised rx==0 and rx_d==1.
- Bit counter: 16 bits, counts 0..BAUD_DIV-1. Bit index: 3 bits.
- FSM states:
  - IDLE: on start detect, go to START and clear the counter.
  - START: count to BAUD_DIV/2-1 (integer division), then sample rx.
    - rx==1: false start, return to IDLE with no pulse.
    - rx==0: go to DATA, clear the counter, bit index=0.
  - DATA: each time the counter reaches BAUD_DIV-1, sample rx into shift[bit index], LSB first. After bit index 7 is sampled, go to STOP.
  - STOP: at counter BAUD_DIV-1, sample rx.
    - rx==1 and byte accepted: on that same edge cmd_out<=byte and rx_done=1 for one cycle.
    - rx==1 and byte filtered out: cmd_reject=1 for one cycle; cmd_out unchanged.
    - rx==0: frame_err=1 for one cycle; cmd_out unchanged.
    - In all cases, go to IDLE.
- Accept rule: FILTER_EN==0, or CMD_MIN <= byte <= CMD_MAX (unsigned compare).
- After a framing error, IDLE needs a fresh high-to-low edge, so a held-low (break) line produces no further frames.
- Latency: from the rx falling edge at the pin to the rx_done edge = 2 sync cycles + BAUD_DIV/2 + 9*BAUD_DIV cycles, ±1 cycle edge-detect quantisation.
- cmd_out is a pure register, stable between accepts; the downstream driver may sample it every cycle.
- rx_done, cmd_reject and frame_err are mutually exclusive and never high for more than one cycle.
- busy = (state != IDLE), registered alongside the state.
- Edges on rx during START/DATA/STOP are ignored; there is no resynchronisation mid-frame.
- Reset asserted mid-frame: FSM returns to IDLE, cmd_out returns to RESET_CMD, and no pulse is emitted. A frame still in progress when reset is released is not decoded correctly; the bench must idle the line for ≥10 bit times.

Test Plan:
- BAUD_DIV=16, send 0x32 ('2') with a valid stop bit -> rx_done pulses once at 2+8+144 (±1) cycles after the start edge; cmd_out=8'd50 and stays held for 1000 cycles.
- Send 0x34, then 0x31 back-to-back (zero idle between frames) -> cmd_out goes 52 then 49; two rx_done pulses exactly 160 cycles apart.
- FILTER_EN=1, send 0x41 ('A') -> cmd_reject pulses, rx_done stays 0, cmd_out keeps its previous value (49). Same byte with FILTER_EN=0 -> cmd_out=8'h41.
- Send 0x33 with the stop bit forced 0 -> frame_err pulses and cmd_out is unchanged. Then hold rx low for 50 bit times -> no further pulses; the next valid 0x33 is accepted.
- 3-cycle low glitch on idle rx -> START sample reads 1, FSM returns to IDLE with no pulses; busy high only during the glitch window (≤ BAUD_DIV/2+3 cycles).
- Assert rst_n low at data bit 4 of 0x32 while cmd_out=52 -> cmd_out=49 immediately (asynchronously), busy=0. After release plus 10 idle bit times, a new 0x32 frame is received correctly.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with servo command filter: a byte is accepted into a held
// command register, rejected as out of range, or flagged as a framing error.
module uart_cmd_rx #(
    parameter int unsigned BAUD_DIV  = 5208,
    parameter logic [7:0]  CMD_MIN   = 8'd49,
    parameter logic [7:0]  CMD_MAX   = 8'd52,
    parameter logic [7:0]  RESET_CMD = 8'd49,
    parameter bit          FILTER_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] cmd_out,
    output logic       rx_done,
    output logic       cmd_reject,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] CNT_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] CNT_HALF = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        done_q, done_d;
    logic        rej_q, rej_d;
    logic        ferr_q, ferr_d;
    logic        busy_q, busy_d;

    logic rx_meta_q, rx_sync_q, rx_dly_q;
    logic start_det;
    logic accept;

    assign start_det = !rx_sync_q && rx_dly_q;
    assign accept    = !FILTER_EN || ((shift_q >= CMD_MIN) && (shift_q <= CMD_MAX));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        cmd_d     = cmd_q;
        done_d    = 1'b0;
        rej_d     = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d = START;
                    cnt_d   = 16'd0;
                end
            end
            START: begin
                // Mid-start-bit check filters out glitches shorter than half a bit
                if (cnt_q == CNT_HALF) begin
                    cnt_d = 16'd0;
                    if (rx_sync_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d              = 16'd0;
                    shift_d[bit_idx_q] = rx_sync_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                    if (!rx_sync_q) begin
                        ferr_d = 1'b1;
                    end else if (accept) begin
                        cmd_d  = shift_q;
                        done_d = 1'b1;
                    end else begin
                        rej_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_dly_q  <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            cmd_q     <= RESET_CMD;
            done_q    <= 1'b0;
            rej_q     <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_dly_q  <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            cmd_q     <= cmd_d;
            done_q    <= done_d;
            rej_q     <= rej_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign cmd_out    = cmd_q;
    assign rx_done    = done_q;
    assign cmd_reject = rej_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: frames are queued as expected pulses and a
// negedge monitor checks every status pulse against the queue.
module tb_uart_cmd_rx;

    localparam int BD = 16;
    localparam logic [1:0] K_DONE = 2'd0;
    localparam logic [1:0] K_REJ  = 2'd1;
    localparam logic [1:0] K_FERR = 2'd2;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] cmd_out, cmd_out_nf;
    logic       rx_done, cmd_reject, frame_err, busy;
    logic       rx_done_nf, cmd_reject_nf, frame_err_nf, busy_nf;

    uart_cmd_rx #(.BAUD_DIV(BD), .FILTER_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .cmd_out(cmd_out),
        .rx_done(rx_done), .cmd_reject(cmd_reject), .frame_err(frame_err), .busy(busy)
    );

    uart_cmd_rx #(.BAUD_DIV(BD), .FILTER_EN(1'b0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .rx(rx), .cmd_out(cmd_out_nf),
        .rx_done(rx_done_nf), .cmd_reject(cmd_reject_nf), .frame_err(frame_err_nf), .busy(busy_nf)
    );

    typedef struct {
        logic [1:0] kind;
        logic [7:0] cmd;
        int         lo;
        int         hi;
        bit         gap;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    logic [7:0] exp_cmd;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every status pulse pops one expectation
    always @(negedge clk) begin
        if (rx_done || cmd_reject || frame_err) begin
            logic [1:0] k;
            exp_t       e;
            k = rx_done ? K_DONE : (cmd_reject ? K_REJ : K_FERR);
            $display("pulse kind=%0d cmd_out=%0d cyc=%0d", k, cmd_out, cyc);
            check("pulse_exclusive", int'(rx_done) + int'(cmd_reject) + int'(frame_err), 1);
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse actual=kind%0d required=none", k);
            end else begin
                e = sb_q.pop_front();
                if (k != e.kind) begin
                    n_err++;
                    $display("FAIL pulse_kind actual=%0d required=%0d", k, e.kind);
                end
                check("pulse_cmd_out", cmd_out, e.cmd);
                n_cmp++;
                if (cyc < e.lo || cyc > e.hi) begin
                    n_err++;
                    $display("FAIL pulse_latency actual=%0d required=%0d..%0d", cyc, e.lo, e.hi);
                end
                if (e.gap) check("pulse_gap", cyc - last_cyc, 160);
            end
            last_cyc = cyc;
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BD) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    // Caller stays aligned at posedge+1; start edge lands at the current cycle
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic [1:0] kind, input bit gap);
        exp_t e;
        if (kind == K_DONE) exp_cmd = b;
        e.kind = kind;
        e.cmd  = exp_cmd;
        e.lo   = cyc + 153;
        e.hi   = cyc + 155;
        e.gap  = gap;
        sb_q.push_back(e);
        $display("send byte=0x%02h stop=%0d cyc=%0d", b, stop_bit, cyc);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    initial begin
        int         bad;
        int         busy_cnt;
        logic [7:0] b;

        rst_n   = 1'b0;
        rx      = 1'b1;
        exp_cmd = 8'd49;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_out", cmd_out, 49);
        check("reset_rx_done", rx_done, 0);
        check("reset_cmd_reject", cmd_reject, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        idle_bits(10);

        send_frame(8'h32, 1'b1, K_DONE, 1'b0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (cmd_out != 8'd50) bad++;
        end
        check("hold_cmd_50", bad, 0);

        send_frame(8'h34, 1'b1, K_DONE, 1'b0);
        send_frame(8'h31, 1'b1, K_DONE, 1'b1);
        idle_bits(2);
        check("b2b_cmd_49", cmd_out, 49);

        send_frame(8'h41, 1'b1, K_REJ, 1'b0);
        idle_bits(1);
        check("reject_hold_cmd", cmd_out, 49);
        check("nofilter_cmd_41", cmd_out_nf, 8'h41);

        send_frame(8'h33, 1'b0, K_FERR, 1'b0);
        repeat (50) drive_bit(1'b0);
        idle_bits(2);
        check("ferr_hold_cmd", cmd_out, 49);
        send_frame(8'h33, 1'b1, K_DONE, 1'b0);
        idle_bits(1);

        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 2 * BD; i++) begin
            if (i == 3) rx = 1'b1;
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
        end
        n_cmp++;
        if (busy_cnt < 1 || busy_cnt > BD / 2 + 3) begin
            n_err++;
            $display("FAIL glitch_busy actual=%0d required=1..%0d", busy_cnt, BD / 2 + 3);
        end
        check("glitch_busy_end", busy, 0);
        check("glitch_cmd", cmd_out, 51);

        send_frame(8'h34, 1'b1, K_DONE, 1'b0);
        idle_bits(1);
        check("pre_reset_cmd_52", cmd_out, 52);
        b = 8'h32;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (BD / 2) @(posedge clk);
        #1;
        check("midframe_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_cmd", cmd_out, 49);
        check("async_reset_busy", busy, 0);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cmd = 8'd49;
        idle_bits(10);
        send_frame(8'h32, 1'b1, K_DONE, 1'b0);
        idle_bits(2);
        check("post_reset_cmd_50", cmd_out, 50);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
